// File: rtl/argmax_scanner.sv
// argmax_scanner: multi-lane sequential arg-max with optional top-2 margin (macro ARGMAX_TOP2_MARGIN_EN)
module argmax_scanner #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int LANES       = 2,
  parameter int SIGNED_MODE = 1,
  localparam int INDEX_WIDTH = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] inData,
  input  logic                              inValid,
  output logic                              inReady,
  output logic [INDEX_WIDTH-1:0]            outIndex,
  output logic [DATA_WIDTH-1:0]             outValue,
  output logic [DATA_WIDTH-1:0]             outMargin,
  output logic                              outValid,
  input  logic                              outReady
);
  localparam int GROUPS = (NUM_CLASSES + LANES - 1) / LANES;
  localparam int PAD_W  = GROUPS * LANES * DATA_WIDTH;
  localparam int PTR_W  = $clog2(GROUPS * LANES + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  r_state, w_next;
  logic [PAD_W-1:0]        r_data;
  logic [PTR_W-1:0]        r_ptr;
  logic                    r_has, w_has;
  logic [DATA_WIDTH-1:0]   r_best, w_best, w_elem, w_margin;
  logic [INDEX_WIDTH-1:0]  r_bidx, w_bidx;
  logic [INDEX_WIDTH-1:0]  r_index;
  logic [DATA_WIDTH-1:0]   r_value, r_margin;
  logic                    w_last;
`ifdef ARGMAX_TOP2_MARGIN_EN
  logic                    r_has2, w_has2;
  logic [DATA_WIDTH-1:0]   r_second, w_second;
`endif

  function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    return (SIGNED_MODE != 0) ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

`ifdef ARGMAX_TOP2_MARGIN_EN
  function automatic logic [DATA_WIDTH:0] ext(input logic [DATA_WIDTH-1:0] v);
    return {(SIGNED_MODE != 0) & v[DATA_WIDTH-1], v};
  endfunction
`endif

  assign w_last    = int'(r_ptr) + LANES >= NUM_CLASSES;
  assign outIndex  = r_index;
  assign outValue  = r_value;
  assign outMargin = r_margin;

  // State register
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;

  // Next state and handshake outputs
  always_comb begin
    w_next = r_state;
    inReady = 1'b0;
    outValid = 1'b0;
    case (r_state)
      IDLE: begin
        inReady = reset;
        w_next = inValid ? SCAN : IDLE;
      end
      SCAN: w_next = w_last ? DONE : SCAN;
      DONE: begin
        outValid = 1'b1;
        w_next = outReady ? IDLE : DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Lane compare chain: lower lane wins ties, strictly-greater replaces best
  always_comb begin
    w_has = r_has;
    w_best = r_best;
    w_bidx = r_bidx;
    w_elem = '0;
`ifdef ARGMAX_TOP2_MARGIN_EN
    w_has2 = r_has2;
    w_second = r_second;
`endif
    for (int l = 0; l < LANES; l++) begin
      w_elem = r_data[l*DATA_WIDTH +: DATA_WIDTH];
      if (int'(r_ptr) + l < NUM_CLASSES) begin
        if (!w_has || gt(w_elem, w_best)) begin
`ifdef ARGMAX_TOP2_MARGIN_EN
          w_second = w_best;
          w_has2 = w_has;
`endif
          w_best = w_elem;
          w_bidx = INDEX_WIDTH'(int'(r_ptr) + l);
          w_has = 1'b1;
        end
`ifdef ARGMAX_TOP2_MARGIN_EN
        else if (!w_has2 || gt(w_elem, w_second)) begin
          w_second = w_elem;
          w_has2 = 1'b1;
        end
`endif
      end
    end
  end

  // Margin between best and runner-up; zero when there is no runner-up
  always_comb begin
`ifdef ARGMAX_TOP2_MARGIN_EN
    w_margin = w_has2 ? DATA_WIDTH'(ext(w_best) - ext(w_second)) : '0;
`else
    w_margin = '0;
`endif
  end

  // Capture vector, advance scan window, latch result on the last group
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_data <= '0;
      r_ptr <= '0;
      r_has <= 1'b0;
      r_best <= '0;
      r_bidx <= '0;
      r_index <= '0;
      r_value <= '0;
      r_margin <= '0;
`ifdef ARGMAX_TOP2_MARGIN_EN
      r_has2 <= 1'b0;
      r_second <= '0;
`endif
    end else if (r_state == IDLE && inValid) begin
      r_data <= PAD_W'(inData);
      r_ptr <= '0;
      r_has <= 1'b0;
      r_best <= '0;
      r_bidx <= '0;
`ifdef ARGMAX_TOP2_MARGIN_EN
      r_has2 <= 1'b0;
      r_second <= '0;
`endif
    end else if (r_state == SCAN) begin
      r_data <= r_data >> (LANES * DATA_WIDTH);
      r_ptr <= r_ptr + PTR_W'(LANES);
      r_has <= w_has;
      r_best <= w_best;
      r_bidx <= w_bidx;
`ifdef ARGMAX_TOP2_MARGIN_EN
      r_has2 <= w_has2;
      r_second <= w_second;
`endif
      if (w_last) begin
        r_index <= w_bidx;
        r_value <= w_best;
        r_margin <= w_margin;
      end
    end
endmodule

// File: tb/tb_argmax_scanner.sv
// tb_argmax_scanner: randomized and directed checks of argmax_scanner against a behavioural model
module tb_argmax_scanner;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [159:0] in_data = '0;
  logic         in_valid [4];
  logic         out_ready [4];
  logic         in_ready [4];
  logic         out_valid [4];
  logic [3:0]   out_index [4];
  logic [15:0]  out_value [4];
  logic [15:0]  out_margin [4];
  int           checks = 0;
  int           failures = 0;
  int           lat_exp [4] = '{5, 5, 4, 1};
  bit           sgn [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  argmax_scanner #(.NUM_CLASSES(10), .DATA_WIDTH(16), .LANES(2), .SIGNED_MODE(1)) u0 (
    .clk(clk), .reset(reset), .inData(in_data), .inValid(in_valid[0]), .inReady(in_ready[0]),
    .outIndex(out_index[0]), .outValue(out_value[0]), .outMargin(out_margin[0]),
    .outValid(out_valid[0]), .outReady(out_ready[0]));
  argmax_scanner #(.NUM_CLASSES(10), .DATA_WIDTH(16), .LANES(2), .SIGNED_MODE(0)) u1 (
    .clk(clk), .reset(reset), .inData(in_data), .inValid(in_valid[1]), .inReady(in_ready[1]),
    .outIndex(out_index[1]), .outValue(out_value[1]), .outMargin(out_margin[1]),
    .outValid(out_valid[1]), .outReady(out_ready[1]));
  argmax_scanner #(.NUM_CLASSES(10), .DATA_WIDTH(16), .LANES(3), .SIGNED_MODE(1)) u2 (
    .clk(clk), .reset(reset), .inData(in_data), .inValid(in_valid[2]), .inReady(in_ready[2]),
    .outIndex(out_index[2]), .outValue(out_value[2]), .outMargin(out_margin[2]),
    .outValid(out_valid[2]), .outReady(out_ready[2]));
  argmax_scanner #(.NUM_CLASSES(10), .DATA_WIDTH(16), .LANES(10), .SIGNED_MODE(1)) u3 (
    .clk(clk), .reset(reset), .inData(in_data), .inValid(in_valid[3]), .inReady(in_ready[3]),
    .outIndex(out_index[3]), .outValue(out_value[3]), .outMargin(out_margin[3]),
    .outValid(out_valid[3]), .outReady(out_ready[3]));

  // Reference: first index of the maximum; runner-up is the max of all other positions
  function automatic void model(input logic [159:0] v, input bit s, output int idx,
                                output logic [15:0] val, output logic [15:0] mar);
    int e [10];
    int second;
    bit found;
    for (int i = 0; i < 10; i++) e[i] = s ? int'($signed(v[i*16 +: 16])) : int'(v[i*16 +: 16]);
    idx = 0;
    for (int i = 1; i < 10; i++) if (e[i] > e[idx]) idx = i;
    found = 0;
    second = 0;
    for (int i = 0; i < 10; i++)
      if (i != idx && (!found || e[i] > second)) begin
        second = e[i];
        found = 1;
      end
    val = v[idx*16 +: 16];
`ifdef ARGMAX_TOP2_MARGIN_EN
    mar = 16'(e[idx] - second);
`else
    mar = '0;
`endif
  endfunction

  function automatic logic [159:0] fill(input logic [15:0] base);
    logic [159:0] v;
    for (int i = 0; i < 10; i++) v[i*16 +: 16] = base;
    return v;
  endfunction

  task automatic send(input int k, input logic [159:0] v);
    @(negedge clk);
    in_data = v;
    in_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    in_data = {5{$urandom()}};
  endtask

  task automatic wait_out(input int k, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid[k] && lat < 64);
  endtask

  task automatic pop(input int k);
    @(negedge clk);
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #23;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b0 || out_index[k] !== 4'd0 ||
          out_value[k] !== 16'd0 || out_margin[k] !== 16'd0) begin
        failures++;
        $display("FAIL reset[%0d]: valid=%b ready=%b idx=%0d val=%h mar=%h, want all zero", k,
                 out_valid[k], in_ready[k], out_index[k], out_value[k], out_margin[k]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1) begin
        failures++;
        $display("FAIL reset_release[%0d]: inReady=%b want 1", k, in_ready[k]);
      end
    end
  endtask

  task automatic test_directed;
    logic [159:0] v;
    int lat;
    v = fill(16'h0100);
    v[7*16 +: 16] = 16'h0A00;
    send(0, v);
    wait_out(0, lat);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL directed_latency: got %0d want 5", lat);
    end
    checks++;
    if (out_index[0] !== 4'd7 || out_value[0] !== 16'h0A00) begin
      failures++;
      $display("FAIL directed_result: idx=%0d val=%h want 7 0a00", out_index[0], out_value[0]);
    end
    checks++;
`ifdef ARGMAX_TOP2_MARGIN_EN
    if (out_margin[0] !== 16'h0900) begin
`else
    if (out_margin[0] !== 16'h0000) begin
`endif
      failures++;
      $display("FAIL directed_margin: got %h", out_margin[0]);
    end
    pop(0);
  endtask

  task automatic test_signed_unsigned;
    logic [159:0] v;
    logic [15:0] ev, em;
    int ei, lat;
    v = fill(16'hFF00);
    v[3*16 +: 16] = 16'h0100;
    for (int k = 0; k < 2; k++) begin
      send(k, v);
      wait_out(k, lat);
      model(v, sgn[k], ei, ev, em);
      checks++;
      if (lat !== 5 || out_index[k] !== 4'(ei) || out_value[k] !== ev || out_margin[k] !== em) begin
        failures++;
        $display("FAIL sign_mode[%0d]: lat=%0d idx=%0d val=%h mar=%h want 5 %0d %h %h",
                 k, lat, out_index[k], out_value[k], out_margin[k], ei, ev, em);
      end
      pop(k);
    end
    checks++;
    if (ei !== 0 || ev !== 16'hFF00 || em !== 16'h0000) begin
      failures++;
      $display("FAIL unsigned_model: idx=%0d val=%h mar=%h want 0 ff00 0000", ei, ev, em);
    end
  endtask

  task automatic test_tie;
    logic [159:0] v;
    int lat;
    v = '0;
    v[2*16 +: 16] = 16'h1FC0;
    v[5*16 +: 16] = 16'h1FC0;
    for (int k = 0; k < 4; k++) begin
      send(k, v);
      wait_out(k, lat);
      checks++;
      if (lat !== lat_exp[k] || out_index[k] !== 4'd2 || out_value[k] !== 16'h1FC0 ||
          out_margin[k] !== 16'h0000) begin
        failures++;
        $display("FAIL tie[%0d]: lat=%0d idx=%0d val=%h mar=%h want %0d 2 1fc0 0000",
                 k, lat, out_index[k], out_value[k], out_margin[k], lat_exp[k]);
      end
      pop(k);
    end
  endtask

  task automatic test_partial_group;
    logic [159:0] v;
    logic [15:0] ev, em;
    int ei, lat;
    v = fill(16'h0010);
    v[9*16 +: 16] = 16'h0300;
    for (int k = 2; k < 4; k++) begin
      send(k, v);
      wait_out(k, lat);
      model(v, 1'b1, ei, ev, em);
      checks++;
      if (lat !== lat_exp[k] || out_index[k] !== 4'd9 || out_value[k] !== ev || out_margin[k] !== em) begin
        failures++;
        $display("FAIL partial[%0d]: lat=%0d idx=%0d val=%h mar=%h want %0d 9 %h %h",
                 k, lat, out_index[k], out_value[k], out_margin[k], lat_exp[k], ev, em);
      end
      pop(k);
    end
  endtask

  task automatic test_backpressure;
    logic [159:0] a, b;
    logic [15:0] av, am, bv, bm;
    int ai, bi, lat;
    bit bad;
    a = {5{$urandom()}};
    b = {5{$urandom()}};
    model(a, 1'b1, ai, av, am);
    model(b, 1'b1, bi, bv, bm);
    send(0, a);
    wait_out(0, lat);
    @(negedge clk);
    in_data = b;
    in_valid[0] = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_index[0] !== 4'(ai) ||
          out_value[0] !== av || out_margin[0] !== am) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold: valid=%b ready=%b idx=%0d val=%h mar=%h want 1 0 %0d %h %h",
               out_valid[0], in_ready[0], out_index[0], out_value[0], out_margin[0], ai, av, am);
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL bp_transfer: valid=%b ready=%b want 0 1", out_valid[0], in_ready[0]);
    end
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept: inReady=%b want 0 after second accept", in_ready[0]);
    end
    wait_out(0, lat);
    checks++;
    if (lat !== 5 || out_index[0] !== 4'(bi) || out_value[0] !== bv || out_margin[0] !== bm) begin
      failures++;
      $display("FAIL bp_second: lat=%0d idx=%0d val=%h mar=%h want 5 %0d %h %h",
               lat, out_index[0], out_value[0], out_margin[0], bi, bv, bm);
    end
    pop(0);
  endtask

  task automatic test_reset_mid_scan;
    logic [159:0] v;
    logic [15:0] ev, em;
    int ei, lat;
    send(0, {5{$urandom()}});
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_scan_assert: valid=%b ready=%b want 0 0", out_valid[0], in_ready[0]);
    end
    repeat (6) @(posedge clk);
    checks++;
    if (out_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_scan_hold: valid=%b want 0", out_valid[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_scan_release: inReady=%b want 1", in_ready[0]);
    end
    v = {5{$urandom()}};
    model(v, 1'b1, ei, ev, em);
    send(0, v);
    wait_out(0, lat);
    checks++;
    if (lat !== 5 || out_index[0] !== 4'(ei) || out_value[0] !== ev || out_margin[0] !== em) begin
      failures++;
      $display("FAIL rst_scan_next: lat=%0d idx=%0d val=%h mar=%h want 5 %0d %h %h",
               lat, out_index[0], out_value[0], out_margin[0], ei, ev, em);
    end
    pop(0);
  endtask

  task automatic test_random;
    logic [159:0] v;
    logic [15:0] ev, em;
    logic [15:0] pick [4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
    int ei, lat, k;
    for (int n = 0; n < 40; n++) begin
      k = n % 4;
      for (int i = 0; i < 10; i++)
        case (n % 3)
          0: v[i*16 +: 16] = 16'($urandom());
          1: v[i*16 +: 16] = 16'($urandom_range(0, 3));
          default: v[i*16 +: 16] = pick[$urandom_range(0, 3)];
        endcase
      model(v, sgn[k], ei, ev, em);
      send(k, v);
      wait_out(k, lat);
      checks++;
      if (lat !== lat_exp[k] || out_index[k] !== 4'(ei) || out_value[k] !== ev || out_margin[k] !== em) begin
        failures++;
        $display("FAIL random[%0d] inst %0d: lat=%0d idx=%0d val=%h mar=%h want %0d %0d %h %h",
                 n, k, lat, out_index[k], out_value[k], out_margin[k], lat_exp[k], ei, ev, em);
      end
      pop(k);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
    end
    test_reset;
    test_directed;
    test_signed_unsigned;
    test_tie;
    test_partial_group;
    test_backpressure;
    test_reset_mid_scan;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/argmax_scanner.md
# argmax_scanner

Parametrised, multi-lane sequential arg-max unit for the network output stage. It accepts one flattened score vector (NNout-style, element 0 in the LSBs) through a valid/ready handshake and scans it LANES elements per cycle. It returns the winning class index and value, plus an optional top-2 confidence margin, through a second valid/ready handshake. It replaces the fixed single-mode max logic behind maxIndex/maxValue/maxValid with a configurable block.

## Interface
- NUM_CLASSES, 10, number of score elements (≥1)
- DATA_WIDTH, 16, bits per element (Q8.8 in current network)
- LANES, 2, elements compared per scan cycle (1..NUM_CLASSES)
- SIGNED_MODE, 1, 1 = two's-complement compare, 0 = unsigned compare
- INDEX_WIDTH, max(1,$clog2(NUM_CLASSES)), derived; not overridden

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- inData  in  NUM_CLASSES*DATA_WIDTH  score vector; element i at [i*DATA_WIDTH +: DATA_WIDTH]
- inValid  in  1  inData valid
- inReady  out  1  block can accept a vector
- outIndex  out  INDEX_WIDTH  winning element index
- outValue  out  DATA_WIDTH  winning element value
- outMargin  out  DATA_WIDTH  unsigned (best − second best)
- outValid  out  1  result valid
- outReady  in  1  consumer accepts result

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - inReady = 1 while reset is deasserted.
  - On inValid && inReady: register inData, ptr = 0, clear best/second trackers; go to SCAN.
- SCAN:
  - Each cycle, compare elements ptr..ptr+LANES−1 against the running best.
  - Lanes with index ≥ NUM_CLASSES are ignored.
  - ptr += LANES each cycle.
  - After C = ceil(NUM_CLASSES/LANES) scan cycles, go to DONE.
- Compare rule:
  - Replace only on strictly greater, so ties resolve to the lowest index.
  - Within a lane group, lower lane index has priority.
- First element seeds best. Initial trackers never win over a real element.
- DONE:
  - outValid = 1; outputs held stable until outReady.
  - On outValid && outReady, go to IDLE.
- Input is captured, so inData may change after the accept edge.
- Widths:
  - Margin = best − second, computed DATA_WIDTH+1 wide. The result is always non-negative and fits DATA_WIDTH unsigned.
  - NUM_CLASSES = 1 gives margin 0.
  - Ties for best give margin 0.

## Timing
- Reset values:
  - state IDLE, outValid 0, outIndex 0, outValue 0, outMargin 0.
  - inReady is 0 while reset is asserted and 1 in the first cycle after release.
- Latency:
  - Accept at edge E0; scan on edges E1..EC.
  - outValid rises after edge EC and is high in cycle C+1 after accept.
  - Example: N=10, LANES=2 gives outValid 5 cycles after the accept edge.
- Result handshake: transfer on the edge where outValid && outReady. outValid drops after that edge; inReady is 1 in the next cycle.
- inReady is 0 throughout SCAN and DONE. inValid in those states is ignored, and the source holds it.
- Throughput: one vector per C+2 cycles with outReady tied high.
- Reset asserted mid-SCAN or in DONE: immediate return to IDLE, outValid 0, partial results discarded.

## Configuration
- Macro ARGMAX_TOP2_MARGIN_EN.
- Defined: second-best tracker and subtractor built; outMargin as specified. The second-best tracker updates when a value displaces best, or when a value is ≤ best and > second.
- Undefined: no second-best registers; outMargin tied to 0. Index, value and latency are unchanged.

## Test plan
- N=10, LANES=2, signed, macro on:
  - Stimulus: element 7 = 0x0A00, rest 0x0100.
  - Required: outIndex 7, outValue 0x0A00, outMargin 0x0900, outValid 5 cycles after accept.
- Signed vs unsigned:
  - Stimulus: element 3 = 0x0100, rest 0xFF00.
  - SIGNED_MODE=1 gives index 3, margin 0x0200.
  - SIGNED_MODE=0 gives index 0, value 0xFF00, margin 0.
- Tie:
  - Stimulus: elements 2 and 5 = 0x1FC0, rest 0x0000.
  - Required: index 2, value 0x1FC0, margin 0.
- Backpressure:
  - Stimulus: outReady low for 10 cycles in DONE, with inValid high and a new vector present.
  - Required: outputs stable, inReady 0, second vector accepted only the cycle after the result transfer.
- Reset mid-SCAN:
  - Stimulus: reset low at scan cycle 2.
  - Required: outValid 0 immediately, inReady 1 after release; the next vector produces the correct result with normal latency.
- Partial last group:
  - LANES=3, N=10 (C=4): max in element 9 is found, outValid after 4 scan cycles.
  - LANES=10: outValid 1 cycle after accept.
